// File: rtl/user_io_ports_if.sv
// Bus bundle for user_io_ports: CPU decode/read-mux signals plus the
// valid/ready handshakes of the two input ports and the output port.
interface user_io_ports_if #(
  parameter int DW = 32
);
  logic [1:0]    mux_sel;
  logic          out_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] in0_data;
  logic [DW-1:0] in1_data;
  logic          in0_valid;
  logic          in1_valid;
  logic          in0_ready;
  logic          in1_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  // Controller / external-device side
  modport master (
    output mux_sel, out_en, wr_data, in0_data, in1_data, in0_valid, in1_valid, out_ready,
    input  rd_data, in0_ready, in1_ready, out_data, out_valid
  );

  // Peripheral side
  modport slave (
    input  mux_sel, out_en, wr_data, in0_data, in1_data, in0_valid, in1_valid, out_ready,
    output rd_data, in0_ready, in1_ready, out_data, out_valid
  );
endinterface

// File: rtl/user_io_ports.sv
// Memory-mapped user I/O: two input holding registers, a 2-entry output FIFO,
// sticky over/underflow status. Define USER_IO_SYNC_EN to add 2-flop input synchronizers.
module user_io_ports #(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  user_io_ports_if.slave   bus
);

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_STATUS = 2'b11;

  logic [DW-1:0] raw_data_w [2];
  logic [1:0]    raw_valid_w;
  logic [DW-1:0] in_data_w [2];
  logic [1:0]    in_valid_w;
  logic          out_ready_w;

  assign raw_data_w[0] = bus.in0_data;
  assign raw_data_w[1] = bus.in1_data;
  assign raw_valid_w   = {bus.in1_valid, bus.in0_valid};

`ifdef USER_IO_SYNC_EN
  logic [DW-1:0] data_s1_reg [2];
  logic [DW-1:0] data_s2_reg [2];
  logic [1:0]    valid_s1_reg;
  logic [1:0]    valid_s2_reg;
  logic          ready_s1_reg;
  logic          ready_s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_reg <= '0;
      valid_s2_reg <= '0;
      ready_s1_reg <= 1'b0;
      ready_s2_reg <= 1'b0;
    end else begin
      valid_s1_reg <= raw_valid_w;
      valid_s2_reg <= valid_s1_reg;
      ready_s1_reg <= bus.out_ready;
      ready_s2_reg <= ready_s1_reg;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_s1_reg[gi] <= '0;
        data_s2_reg[gi] <= '0;
      end else begin
        data_s1_reg[gi] <= raw_data_w[gi];
        data_s2_reg[gi] <= data_s1_reg[gi];
      end
    end
    assign in_data_w[gi] = data_s2_reg[gi];
  end

  assign in_valid_w  = valid_s2_reg;
  assign out_ready_w = ready_s2_reg;
`else
  for (genvar gi = 0; gi < 2; gi++) begin : g_direct
    assign in_data_w[gi] = raw_data_w[gi];
  end

  assign in_valid_w  = raw_valid_w;
  assign out_ready_w = bus.out_ready;
`endif

  // Level-style decode strobes turned into single-cycle events
  logic [1:0] prev_sel_reg;
  logic       prev_en_reg;
  logic       rd_evt_w;
  logic       wr_evt_w;
  logic       status_rd_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel_reg <= SEL_NONE;
      prev_en_reg  <= 1'b0;
    end else begin
      prev_sel_reg <= bus.mux_sel;
      prev_en_reg  <= bus.out_en;
    end
  end

  assign rd_evt_w    = (bus.mux_sel != SEL_NONE) && (bus.mux_sel != prev_sel_reg);
  assign wr_evt_w    = bus.out_en && !prev_en_reg;
  assign status_rd_w = rd_evt_w && (bus.mux_sel == SEL_STATUS);

  // Input ports: one holding register and full flag each
  logic [DW-1:0] port_data_reg [2];
  logic          full_reg [2];
  logic [1:0]    underflow_hit_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic port_rd_w;
    logic capture_w;

    assign port_rd_w           = rd_evt_w && (bus.mux_sel == 2'(gi + 1));
    assign capture_w           = in_valid_w[gi] && !full_reg[gi];
    assign underflow_hit_w[gi] = port_rd_w && !full_reg[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        port_data_reg[gi] <= '0;
        full_reg[gi]      <= 1'b0;
      end else if (capture_w) begin
        port_data_reg[gi] <= in_data_w[gi];
        full_reg[gi]      <= 1'b1;
      end else if (port_rd_w) begin
        full_reg[gi]      <= 1'b0;
      end
    end
  end

  assign bus.in0_ready = !full_reg[0];
  assign bus.in1_ready = !full_reg[1];

  // Output FIFO: entry 0 is always the head, entry 1 shifts down on pop
  logic [DW-1:0] q_reg [2];
  logic [1:0]    count_reg;
  logic          pop_w;
  logic          overflow_hit_w;

  assign pop_w          = (count_reg != 2'd0) && out_ready_w;
  assign overflow_hit_w = wr_evt_w && (count_reg == 2'd2) && !pop_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg[0]  <= '0;
      q_reg[1]  <= '0;
      count_reg <= 2'd0;
    end else begin
      if (wr_evt_w && pop_w) begin
        if (count_reg == 2'd1) begin
          q_reg[0] <= bus.wr_data;
        end else begin
          q_reg[0] <= q_reg[1];
          q_reg[1] <= bus.wr_data;
        end
      end else if (pop_w) begin
        q_reg[0]  <= q_reg[1];
        count_reg <= count_reg - 2'd1;
      end else if (wr_evt_w && !overflow_hit_w) begin
        if (count_reg == 2'd0) begin
          q_reg[0] <= bus.wr_data;
        end else begin
          q_reg[1] <= bus.wr_data;
        end
        count_reg <= count_reg + 2'd1;
      end
    end
  end

  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_data  = q_reg[0];

  // Sticky flags: a status read clears them, but a new event that cycle wins
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (overflow_hit_w) begin
        overflow_reg <= 1'b1;
      end else if (status_rd_w) begin
        overflow_reg <= 1'b0;
      end
      if (|underflow_hit_w) begin
        underflow_reg <= 1'b1;
      end else if (status_rd_w) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  logic [DW-1:0] status_w;
  assign status_w = {{(DW-6){1'b0}}, underflow_reg, overflow_reg, count_reg,
                     full_reg[1], full_reg[0]};

  always_comb begin
    bus.rd_data = '0;
    case (bus.mux_sel)
      2'b01:   bus.rd_data = port_data_reg[0];
      2'b10:   bus.rd_data = port_data_reg[1];
      2'b11:   bus.rd_data = status_w;
      default: bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_user_io_ports.sv
// Scoreboard bench for user_io_ports: expected read data and output-port words
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_user_io_ports;

  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  logic rd_chk;
  logic [DW-1:0] exp_rd [$];
  logic [DW-1:0] exp_out [$];

  user_io_ports_if #(.DW(DW)) bus ();

  user_io_ports #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares rd_data during CPU reads and every accepted output word
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rd_chk) begin
      n_vec++;
      if (exp_rd.size() == 0) begin
        n_bad++;
        $display("FAIL rd_data: got %h, no expected value queued", bus.rd_data);
      end else begin
        e = exp_rd.pop_front();
        if (bus.rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %h, expected %h", bus.rd_data, e);
        end else begin
          $display("read  sel=%b rd_data=%h ok", bus.mux_sel, bus.rd_data);
        end
      end
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_vec++;
      if (exp_out.size() == 0) begin
        n_bad++;
        $display("FAIL out_data: got unexpected word %h", bus.out_data);
      end else begin
        e = exp_out.pop_front();
        if (bus.out_data !== e) begin
          n_bad++;
          $display("FAIL out_data: got %h, expected %h", bus.out_data, e);
        end else begin
          $display("out   word=%h ok", bus.out_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  // Hold mux_sel for n cycles, expecting the same rd_data each cycle, then idle one cycle
  task automatic cpu_read(input logic [1:0] sel, input logic [DW-1:0] exp, input int n);
    bus.mux_sel = sel;
    for (int i = 0; i < n; i++) exp_rd.push_back(exp);
    rd_chk = 1'b1;
    repeat (n) tick();
    rd_chk = 1'b0;
    bus.mux_sel = 2'b00;
    tick();
  endtask

  task automatic cpu_write(input logic [DW-1:0] d);
    bus.wr_data = d;
    bus.out_en  = 1'b1;
    tick();
    bus.out_en  = 1'b0;
    tick();
  endtask

  task automatic feed(input int port, input logic [DW-1:0] d);
    if (port == 0) begin
      bus.in0_data = d; bus.in0_valid = 1'b1;
    end else begin
      bus.in1_data = d; bus.in1_valid = 1'b1;
    end
    tick();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    bus.out_ready = 1'b1;
    budget = 20;
    while (exp_out.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_out.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_out.size());
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rd_chk = 1'b0;
    bus.mux_sel = 2'b00;
    bus.out_en = 1'b0;
    bus.wr_data = '0;
    bus.in0_data = 32'h1234_5678;
    bus.in1_data = '0;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    // Reset with in0_valid asserted
    repeat (3) tick();
    check("rst_in0_ready", 32'(bus.in0_ready), 32'd1);
    check("rst_in1_ready", 32'(bus.in1_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    bus.in0_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    cpu_read(2'b11, 32'h0, 1);

    // Capture then a held port-0 read pops exactly once
    feed(0, 32'hCAFE_0001);
    check("in0_ready_full", 32'(bus.in0_ready), 32'd0);
    cpu_read(2'b11, 32'h1, 1);
    cpu_read(2'b01, 32'hCAFE_0001, 3);
    check("in0_ready_popped", 32'(bus.in0_ready), 32'd1);
    cpu_read(2'b11, 32'h0, 1);

    // Underflow on empty port 1, cleared by the status read
    cpu_read(2'b10, 32'h0, 1);
    cpu_read(2'b11, 32'h20, 1);
    cpu_read(2'b11, 32'h0, 1);
    feed(1, 32'hBEEF_0002);
    cpu_read(2'b11, 32'h2, 1);
    cpu_read(2'b10, 32'hBEEF_0002, 1);

    // Output queue overflow: third word dropped
    cpu_write(32'h11); exp_out.push_back(32'h11);
    check("out_valid_first", 32'(bus.out_valid), 32'd1);
    cpu_write(32'h22); exp_out.push_back(32'h22);
    cpu_write(32'h33);
    check("out_data_head", bus.out_data, 32'h11);
    cpu_read(2'b11, 32'h18, 1);
    cpu_read(2'b11, 32'h08, 1);
    drain();
    check("out_valid_drained", 32'(bus.out_valid), 32'd0);
    cpu_read(2'b11, 32'h0, 1);

    // Push and pop in the same cycle while full
    cpu_write(32'h66); exp_out.push_back(32'h66);
    cpu_write(32'h77); exp_out.push_back(32'h77);
    bus.wr_data = 32'h44;
    bus.out_en = 1'b1;
    bus.out_ready = 1'b1;
    exp_out.push_back(32'h44);
    tick();
    bus.out_en = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check("pushpop_head", bus.out_data, 32'h77);
    cpu_read(2'b11, 32'h08, 1);
    drain();
    check("pushpop_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with both ports full and two words queued
    feed(0, 32'hA0);
    feed(1, 32'hA1);
    cpu_write(32'h88);
    cpu_write(32'h99);
    cpu_read(2'b11, 32'h0B, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in0_ready", 32'(bus.in0_ready), 32'd1);
    check("arst_in1_ready", 32'(bus.in1_ready), 32'd1);
    exp_out.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_out_data", bus.out_data, 32'h0);
    cpu_read(2'b11, 32'h0, 1);
    cpu_read(2'b01, 32'h0, 1);
    cpu_read(2'b10, 32'h0, 1);

    n_vec++;
    if (exp_rd.size() != 0) begin
      n_bad++;
      $display("FAIL rd_queue_left: got %0d entries, expected 0", exp_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
